sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO. Successor to the fixed 32x32 FIFO used on the AXI
//  channel buffers. Adds configurable width/depth, a fill count, almost-full and
//  almost-empty thresholds, and a synchronous flush. Read mode is selectable:
//  registered 1-cycle read or first-word-fall-through (FWFT).
//  Sits between AXI channel handshakes and the slave memory/control logic.
// PARAMETERS
//  WIDTH     32  data width in bits, >=1
//  DEPTH     32  entries; power of 2, >=4
//  AF_LEVEL  28  almost_full_o asserts when count_o >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  4   almost_empty_o asserts when count_o <= AE_LEVEL (0..DEPTH-1)
//  FWFT      0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
//  CW = $clog2(DEPTH)+1 (local)
// PORTS
//  clk_i           in   1      clock; all state changes on rising edge
//  rst_i           in   1      asynchronous active-low reset
//  clear_i         in   1      synchronous flush, active high
//  wr_en_i         in   1      write request
//  wdata_i         in   WIDTH  write data
//  full_o          out  1      count_o == DEPTH
//  almost_full_o   out  1      count_o >= AF_LEVEL
//  overflow_o      out  1      1-cycle pulse: previous-cycle write was rejected
//  rd_en_i         in   1      read request (FWFT=1: pop/acknowledge of rdata_o)
//  rdata_o         out  WIDTH  read data
//  rdata_valid_o   out  1      FWFT=0: 1-cycle pulse with new rdata_o; FWFT=1: equals !empty_o
//  empty_o         out  1      count_o == 0
//  almost_empty_o  out  1      count_o <= AE_LEVEL
//  underflow_o     out  1      1-cycle pulse: previous-cycle read was rejected
//  count_o         out  CW     entries currently stored, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_i=0, async): pointers=0, count_o=0, empty_o=1, almost_empty_o=1,
//   full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, rdata_valid_o=0,
//   rdata_o=0 (FWFT=0). Storage array is not reset.
//   rst_i asserted mid-burst discards all contents; first edge after release is normal.
//  Write accepted at an edge iff wr_en_i && !full_o && !clear_i; a write while full
//   is rejected even if a read happens in the same cycle -> overflow_o=1 next cycle.
//  Read accepted at an edge iff rd_en_i && !empty_o && !clear_i; a read while empty
//   is rejected even if a write happens in the same cycle -> underflow_o=1 next cycle.
//  Simultaneous accepted write+read: count_o unchanged; both pointers advance.
//  count_o: +1 on write only, -1 on read only. All flags are decoded from the count
//   register, so they reflect an edge's update in the cycle after that edge.
//  Pointers are CW-1 bits wide and wrap DEPTH-1 -> 0 with no gap. Full and empty
//   are distinguished by count_o.
//  FWFT=0: an accepted read at edge N loads rdata_o=mem[rd_ptr] at edge N, and
//   rdata_valid_o=1 for exactly that cycle. rdata_o holds its value otherwise.
//  FWFT=1: rdata_o = mem[rd_ptr] combinationally, valid while !empty_o. The first
//   write into an empty FIFO appears on rdata_o the cycle after the write edge.
//   An accepted rd_en_i pops the word; the next word appears after that edge.
//  clear_i: priority over wr/rd in that cycle. Pointers and count go to 0, no
//   overflow/underflow, rdata_valid_o=0. rdata_o holds its value (FWFT=0).
// TESTING
//  1 Reset: rst_i low mid-operation -> empty_o=1, almost_empty_o=1, count_o=0,
//    and all pulses 0 immediately, without waiting for a clock edge.
//  2 Fill/drain (FWFT=0, DEPTH=32): write 0..31 -> full_o=1, count_o=32 and
//    almost_full_o from count 28. Read 32 -> rdata_o=0..31, each with a
//    rdata_valid_o pulse, then empty_o=1.
//  3 Boundaries: write when full -> overflow_o=1 for one cycle, data unchanged.
//    Read when empty -> underflow_o=1 for one cycle, rdata_o unchanged.
//  4 Concurrent: at count 5, wr+rd for 100 cycles -> count_o stays 5, order
//    preserved across pointer wrap. Wr+rd at count 0 -> write only, underflow_o=1.
//    Wr+rd at count 32 -> read only, overflow_o=1.
//  5 FWFT=1: write 0xA5 into an empty FIFO -> rdata_o=0xA5, rdata_valid_o=1 the
//    next cycle. Pulse rd_en_i -> empty_o=1.
//  6 clear_i with count 17 and wr_en_i=1 -> count_o=0, empty_o=1, no overflow_o.
//    The next write of 0x3C reads back as 0x3C.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO used between AXI channel handshakes and the
//   slave memory/control logic. It provides a fill count, almost-full and
//   almost-empty thresholds, a synchronous flush, and a choice of read style:
//   registered 1-cycle read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Parameters
//   WIDTH     data width in bits (>=1)
//   DEPTH     number of entries, power of two (>=4)
//   AF_LEVEL  almost_full_o  when count_o >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty_o when count_o <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active low
//   clear_i         synchronous flush, active high, wins over wr/rd
//   wr_en_i/wdata_i write request and data
//   full_o          count_o == DEPTH
//   almost_full_o   count_o >= AF_LEVEL
//   overflow_o      pulse: the previous cycle's write was rejected
//   rd_en_i         read request (FWFT=1: pop of the word shown on rdata_o)
//   rdata_o         read data
//   rdata_valid_o   FWFT=0: pulse with new rdata_o; FWFT=1: !empty_o
//   empty_o         count_o == 0
//   almost_empty_o  count_o <= AE_LEVEL
//   underflow_o     pulse: the previous cycle's read was rejected
//   count_o         number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   overflow_o,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   rdata_valid_o,
  output logic                   empty_o,
  output logic                   almost_empty_o,
  output logic                   underflow_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_accept;
  logic          rd_accept;

  // Flags come straight from the count register, so they show an edge's
  // update in the following cycle.
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // A write into a full FIFO is rejected even if a read pops in the same
  // cycle; likewise a read from an empty FIFO ignores a concurrent write.
  assign wr_accept = wr_en_i && !full_o  && !clear_i;
  assign rd_accept = rd_en_i && !empty_o && !clear_i;

  // NOTE: every signal driven here gets its default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en_i && full_o  && !clear_i;
    underflow_d = rd_en_i && empty_o && !clear_i;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits, so DEPTH-1 -> 0 wraps for free.
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;

      if (wr_accept && !rd_accept) begin
        count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only ever observed
  // behind the count, so clearing it would cost flops and buy nothing.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  if (FWFT) begin : g_fwft
    // Head of the queue is always presented; rd_en_i acts as the pop.
    assign rdata_o       = mem_q[rd_ptr_q];
    assign rdata_valid_o = !empty_o;
  end else begin : g_registered
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // rdata_q only moves on an accepted read, so it holds across idle,
    // rejected and flush cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_accept;
        if (rd_accept) begin
          rdata_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Self-checking bench for sync_fifo_param. Instance u_reg uses the default
//   registered-read configuration (32x32); instance u_fwft is a small 8x8
//   first-word-fall-through FIFO. Written words are pushed to a scoreboard
//   queue and popped whenever the registered FIFO presents read data.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Registered-read FIFO, defaults (WIDTH=32, DEPTH=32, AF=28, AE=4)
  logic        a_clear, a_wr, a_rd;
  logic [31:0] a_wdata, a_rdata;
  logic        a_full, a_af, a_ovf, a_valid, a_empty, a_ae, a_unf;
  logic [5:0]  a_count;

  // FWFT FIFO, WIDTH=8, DEPTH=8, AF=6, AE=1
  logic        b_clear, b_wr, b_rd;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_full, b_af, b_ovf, b_valid, b_empty, b_ae, b_unf;
  logic [3:0]  b_count;

  sync_fifo_param u_reg (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .clear_i        (a_clear),
    .wr_en_i        (a_wr),
    .wdata_i        (a_wdata),
    .full_o         (a_full),
    .almost_full_o  (a_af),
    .overflow_o     (a_ovf),
    .rd_en_i        (a_rd),
    .rdata_o        (a_rdata),
    .rdata_valid_o  (a_valid),
    .empty_o        (a_empty),
    .almost_empty_o (a_ae),
    .underflow_o    (a_unf),
    .count_o        (a_count)
  );

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)
  ) u_fwft (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .clear_i        (b_clear),
    .wr_en_i        (b_wr),
    .wdata_i        (b_wdata),
    .full_o         (b_full),
    .almost_full_o  (b_af),
    .overflow_o     (b_ovf),
    .rd_en_i        (b_rd),
    .rdata_o        (b_rdata),
    .rdata_valid_o  (b_valid),
    .empty_o        (b_empty),
    .almost_empty_o (b_ae),
    .underflow_o    (b_unf),
    .count_o        (b_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the registered FIFO
  int          m_count;
  logic        exp_ovf, exp_unf, exp_valid;
  logic [31:0] sb[$];
  logic [31:0] last_rdata;
  logic [31:0] exp_word;

  task automatic model_reset();
    m_count    = 0;
    sb.delete();
    last_rdata = 32'h0;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
    exp_valid  = 1'b0;
  endtask

  // Drive one cycle on the registered FIFO and advance the model using the
  // pre-edge occupancy. Outputs are sampled 1 time unit after the edge.
  task automatic drive_a(input logic wr, input logic rd, input logic clr,
                         input logic [31:0] d);
    bit wacc, racc;
    a_wr = wr; a_rd = rd; a_clear = clr; a_wdata = d;
    wacc      = wr && (m_count < 32) && !clr;
    racc      = rd && (m_count > 0)  && !clr;
    exp_ovf   = wr && (m_count == 32) && !clr;
    exp_unf   = rd && (m_count == 0)   && !clr;
    exp_valid = racc;
    if (clr) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (wacc) sb.push_back(d);
      m_count = m_count + int'(wacc) - int'(racc);
    end
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0; a_clear = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    #1;
    n_checks += 9;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a_empty); end
    if (a_ae    !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", a_ae); end
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_count); end
    if (a_full  !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", a_full); end
    if (a_af    !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", a_af); end
    if (a_ovf   !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    if (a_unf   !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", a_unf); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    n_checks += 2;
    if (b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty: got %b want 1", b_empty); end
    if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwft_valid: got %b want 0", b_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Mid-operation: three writes, one read, then drop reset between edges.
    for (int i = 0; i < 3; i++) drive_a(1'b1, 1'b0, 1'b0, 32'h100 + i);
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    got = a_rdata;
    n_checks += 3;
    if (a_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", a_valid); end
    if (got !== 32'h100)  begin n_fail++; $display("FAIL pre_reset_rdata: got %h want 100", got); end
    if (a_count !== 6'd2) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 2", a_count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL async_reset_empty: got %b want 1", a_empty); end
    if (a_ae    !== 1'b1) begin n_fail++; $display("FAIL async_reset_ae: got %b want 1", a_ae); end
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", a_count); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", a_valid); end
    if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_rdata: got %h want 0", a_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fill_drain();
    for (int i = 0; i < 32; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, 32'(i));
      n_checks += 3;
      if (a_count !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_count, i + 1); end
      if (a_af !== (i + 1 >= 28)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b", i, a_af); end
      if (a_full !== (i + 1 == 32)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b", i, a_full); end
    end
    for (int i = 0; i < 32; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks += 3;
      if (a_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, a_valid); end
      if (a_count !== 6'(31 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, a_count, 31 - i); end
      exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      last_rdata = exp_word;
      if (a_rdata !== exp_word) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, a_rdata, exp_word); end
    end
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks += 3;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", a_empty); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle_valid: got %b want 0", a_valid); end
    if (a_rdata !== 32'd31) begin n_fail++; $display("FAIL drain_hold: got %h want 1f", a_rdata); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_boundaries();
    for (int i = 0; i < 32; i++) drive_a(1'b1, 1'b0, 1'b0, 32'hB000 + i);
    drive_a(1'b1, 1'b0, 1'b0, 32'hDEAD);
    n_checks += 2;
    if (a_ovf !== exp_ovf || a_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse: got %b want 1", a_ovf); end
    if (a_count !== 6'd32) begin n_fail++; $display("FAIL overflow_count: got %0d want 32", a_count); end
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_clears: got %b want 0", a_ovf); end
    for (int i = 0; i < 32; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++;
      if (a_valid !== exp_valid) begin n_fail++; $display("FAIL bound_valid[%0d]: got %b want %b", i, a_valid, exp_valid); end
      if (a_valid === 1'b1) begin
        exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        last_rdata = exp_word;
        n_checks++;
        if (a_rdata !== exp_word) begin n_fail++; $display("FAIL bound_data[%0d]: got %h want %h", i, a_rdata, exp_word); end
      end
    end
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks += 4;
    if (a_unf !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse: got %b want 1", a_unf); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_valid: got %b want 0", a_valid); end
    if (a_rdata !== last_rdata) begin n_fail++; $display("FAIL underflow_hold: got %h want %h", a_rdata, last_rdata); end
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL underflow_count: got %0d want 0", a_count); end
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (a_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clears: got %b want 0", a_unf); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_concurrent();
    for (int i = 0; i < 5; i++) drive_a(1'b1, 1'b0, 1'b0, 32'hC00 + i);
    for (int i = 0; i < 100; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 32'hD00 + i);
      n_checks += 3;
      if (a_count !== 6'd5) begin n_fail++; $display("FAIL conc_count[%0d]: got %0d want 5", i, a_count); end
      if (a_valid !== 1'b1) begin n_fail++; $display("FAIL conc_valid[%0d]: got %b want 1", i, a_valid); end
      exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      last_rdata = exp_word;
      if (a_rdata !== exp_word) begin n_fail++; $display("FAIL conc_data[%0d]: got %h want %h", i, a_rdata, exp_word); end
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 32'h0);
      exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      last_rdata = exp_word;
      n_checks++;
      if (a_rdata !== exp_word) begin n_fail++; $display("FAIL conc_tail[%0d]: got %h want %h", i, a_rdata, exp_word); end
    end
    // wr+rd at count 0: write only
    drive_a(1'b1, 1'b1, 1'b0, 32'hE00);
    n_checks += 4;
    if (a_unf !== 1'b1) begin n_fail++; $display("FAIL conc_empty_unf: got %b want 1", a_unf); end
    if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL conc_empty_ovf: got %b want 0", a_ovf); end
    if (a_count !== 6'd1) begin n_fail++; $display("FAIL conc_empty_count: got %0d want 1", a_count); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL conc_empty_valid: got %b want 0", a_valid); end
    for (int i = 1; i < 32; i++) drive_a(1'b1, 1'b0, 1'b0, 32'hE00 + i);
    // wr+rd at count 32: read only
    drive_a(1'b1, 1'b1, 1'b0, 32'hEFF);
    n_checks += 5;
    if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL conc_full_ovf: got %b want 1", a_ovf); end
    if (a_unf !== 1'b0) begin n_fail++; $display("FAIL conc_full_unf: got %b want 0", a_unf); end
    if (a_count !== 6'd31) begin n_fail++; $display("FAIL conc_full_count: got %0d want 31", a_count); end
    if (a_valid !== 1'b1) begin n_fail++; $display("FAIL conc_full_valid: got %b want 1", a_valid); end
    exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    last_rdata = exp_word;
    if (a_rdata !== exp_word) begin n_fail++; $display("FAIL conc_full_data: got %h want %h", a_rdata, exp_word); end
    for (int i = 0; i < 31; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 32'h0);
      exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      last_rdata = exp_word;
      n_checks++;
      if (a_rdata !== exp_word) begin n_fail++; $display("FAIL conc_drain[%0d]: got %h want %h", i, a_rdata, exp_word); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_clear();
    for (int i = 0; i < 17; i++) drive_a(1'b1, 1'b0, 1'b0, 32'hF00 + i);
    n_checks++;
    if (a_count !== 6'd17) begin n_fail++; $display("FAIL clear_pre_count: got %0d want 17", a_count); end
    drive_a(1'b1, 1'b0, 1'b1, 32'hBAD);
    n_checks += 5;
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL clear_count: got %0d want 0", a_count); end
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL clear_empty: got %b want 1", a_empty); end
    if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %b want 0", a_ovf); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b want 0", a_valid); end
    if (a_rdata !== last_rdata) begin n_fail++; $display("FAIL clear_hold: got %h want %h", a_rdata, last_rdata); end
    drive_a(1'b1, 1'b0, 1'b0, 32'h3C);
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks += 2;
    if (a_valid !== 1'b1) begin n_fail++; $display("FAIL clear_rd_valid: got %b want 1", a_valid); end
    exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    last_rdata = exp_word;
    if (a_rdata !== 32'h3C || exp_word !== 32'h3C) begin n_fail++; $display("FAIL clear_readback: got %h want 3c", a_rdata); end
    // Flush of a full FIFO with wr and rd both requested
    for (int i = 0; i < 32; i++) drive_a(1'b1, 1'b0, 1'b0, 32'hA00 + i);
    drive_a(1'b1, 1'b1, 1'b1, 32'hBAD);
    n_checks += 4;
    if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_full_ovf: got %b want 0", a_ovf); end
    if (a_unf !== 1'b0) begin n_fail++; $display("FAIL clear_full_unf: got %b want 0", a_unf); end
    if (a_count !== 6'd0) begin n_fail++; $display("FAIL clear_full_count: got %0d want 0", a_count); end
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL clear_full_valid: got %b want 0", a_valid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fwft();
    b_wr = 1'b1; b_wdata = 8'hA5; @(posedge clk); #1; b_wr = 1'b0;
    n_checks += 4;
    if (b_rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_first_data: got %h want a5", b_rdata); end
    if (b_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_first_valid: got %b want 1", b_valid); end
    if (b_count !== 4'd1) begin n_fail++; $display("FAIL fwft_first_count: got %0d want 1", b_count); end
    if (b_ae !== 1'b1) begin n_fail++; $display("FAIL fwft_ae_at_1: got %b want 1", b_ae); end
    b_wr = 1'b1; b_wdata = 8'h5A; @(posedge clk); #1; b_wr = 1'b0;
    n_checks += 2;
    if (b_rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_head_stable: got %h want a5", b_rdata); end
    if (b_ae !== 1'b0) begin n_fail++; $display("FAIL fwft_ae_at_2: got %b want 0", b_ae); end
    b_rd = 1'b1; @(posedge clk); #1; b_rd = 1'b0;
    n_checks += 3;
    if (b_rdata !== 8'h5A) begin n_fail++; $display("FAIL fwft_second_data: got %h want 5a", b_rdata); end
    if (b_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_second_valid: got %b want 1", b_valid); end
    if (b_count !== 4'd1) begin n_fail++; $display("FAIL fwft_second_count: got %0d want 1", b_count); end
    b_rd = 1'b1; @(posedge clk); #1; b_rd = 1'b0;
    n_checks += 3;
    if (b_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_empty: got %b want 1", b_empty); end
    if (b_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_empty_valid: got %b want 0", b_valid); end
    if (b_count !== 4'd0) begin n_fail++; $display("FAIL fwft_empty_count: got %0d want 0", b_count); end
    b_rd = 1'b1; @(posedge clk); #1; b_rd = 1'b0;
    n_checks++;
    if (b_unf !== 1'b1) begin n_fail++; $display("FAIL fwft_underflow: got %b want 1", b_unf); end
    @(posedge clk); #1;
    n_checks++;
    if (b_unf !== 1'b0) begin n_fail++; $display("FAIL fwft_underflow_clears: got %b want 0", b_unf); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    a_clear = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
    b_clear = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_boundaries();
    test_concurrent();
    test_clear();
    test_fwft();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
